video_arb_slot: RTL and testbench

- Video channel of the DRAM memory arbiter, directly upstream of the video output subsystem.
- Consumes the video fetch request (video_go), the bandwidth code (video_bw) and the fetch address (video_addr).
- Allocates DRAM slots to video at the requested rate and returns fetched words with video_strobe/video_next.
- Slots not used by video are offered to the CPU channel through cpu_slot.

---
 rtl/video_arb_slot.sv | 127 ++++++++++++
 tb/tb_video_arb_slot.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_arb_slot.sv
// Video channel of the DRAM arbiter: picks video slots from a phase counter, issues reads,
// and returns data after RD_LAT slots. Optional slot statistics: define VIDEO_ARB_SLOTCNT_EN.
module video_arb_slot #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cend,
  input  logic        pre_cend,
  input  logic        video_go,
  input  logic [1:0]  video_bw,
  input  logic [20:0] video_addr,
  output logic        video_next,
  output logic        video_strobe,
  output logic [15:0] video_data,
  output logic        cpu_slot,
  output logic        dram_req,
  output logic [20:0] dram_addr,
  input  logic [15:0] dram_rddata
`ifdef VIDEO_ARB_SLOTCNT_EN
  ,
  input  logic        int_start,
  output logic [15:0] slot_cnt
`endif
);

  logic [2:0]        phase_q, phase_d;
  logic              slot_pend_q, slot_pend_d;
  logic [20:0]       dram_addr_q, dram_addr_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [15:0]       video_data_q, video_data_d;
  logic              strobe_q, strobe_d;
  logic              slot_sel;
  logic              next_hit;
  logic              req;
  logic              pipe_exit;

  always_comb begin
    phase_d = phase_q;
    if (!video_go) begin
      phase_d = 3'd0;
    end else if (cend) begin
      phase_d = phase_q + 3'd1;
    end

    // phase_d is the value the counter holds during the cend that follows this pre_cend
    slot_sel = 1'b0;
    case (video_bw)
      2'b00:   slot_sel = (phase_d == 3'd0);
      2'b01:   slot_sel = (phase_d[1:0] == 2'd0);
      2'b10:   slot_sel = (phase_d[0] == 1'b0);
      default: slot_sel = 1'b1;
    endcase

    next_hit    = pre_cend & video_go & slot_sel;
    slot_pend_d = next_hit;
    dram_addr_d = next_hit ? video_addr : dram_addr_q;
    req         = cend & slot_pend_q;

    pipe_d = pipe_q;
    if (cend) begin
      pipe_d[0] = req;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    pipe_exit    = cend & pipe_q[RD_LAT-1];
    video_data_d = pipe_exit ? dram_rddata : video_data_q;
    strobe_d     = pipe_exit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= 3'd0;
      slot_pend_q  <= 1'b0;
      dram_addr_q  <= 21'd0;
      pipe_q       <= '0;
      video_data_q <= 16'h0000;
      strobe_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      slot_pend_q  <= slot_pend_d;
      dram_addr_q  <= dram_addr_d;
      pipe_q       <= pipe_d;
      video_data_q <= video_data_d;
      strobe_q     <= strobe_d;
    end
  end

  assign video_next   = next_hit;
  assign dram_req     = req;
  assign cpu_slot     = cend & ~slot_pend_q;
  assign dram_addr    = dram_addr_q;
  assign video_data   = video_data_q;
  assign video_strobe = strobe_q;

`ifdef VIDEO_ARB_SLOTCNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] slot_cnt_q, slot_cnt_d;

  // A frame start that coincides with an issue counts that issue in the new frame
  always_comb begin
    cnt_d      = cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (int_start) begin
      slot_cnt_d = cnt_q;
      cnt_d      = req ? 16'd1 : 16'd0;
    end else if (req && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 16'd0;
      slot_cnt_q <= 16'd0;
    end else begin
      cnt_q      <= cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign slot_cnt = slot_cnt_q;
`endif

endmodule

// File: tb/tb_video_arb_slot.sv
// Directed bench for video_arb_slot: two instances (RD_LAT=1 and RD_LAT=3) share one
// slot stream; a scoreboard predicts the returned word from the issuing slot index.
module tb_video_arb_slot;

  logic        clk = 1'b0;
  logic        rst;
  logic        cend;
  logic        preCend;
  logic        videoGo;
  logic [1:0]  videoBw;
  logic [20:0] videoAddr;
  logic [15:0] dramRdData;

  logic        videoNext1, strobe1, cpuSlot1, dramReq1;
  logic [15:0] data1;
  logic [20:0] dramAddr1;
  logic        videoNext3, strobe3, cpuSlot3, dramReq3;
  logic [15:0] data3;
  logic [20:0] dramAddr3;
`ifdef VIDEO_ARB_SLOTCNT_EN
  logic        intStart;
  logic [15:0] slotCnt1, slotCnt3;
`endif

  int checks = 0;
  int errors = 0;
  int slotIdx = 0;
  int nextCnt, reqCnt, cpuCnt, strobeCnt1, strobeCnt3;
  int sb1[$];
  int sb3[$];
  int reqSlotQ[$];
  logic [20:0] reqAddrQ[$];
  logic prevCend = 1'b0;

  always #5 clk = ~clk;

  video_arb_slot #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .cend(cend), .pre_cend(preCend), .video_go(videoGo),
    .video_bw(videoBw), .video_addr(videoAddr), .video_next(videoNext1),
    .video_strobe(strobe1), .video_data(data1), .cpu_slot(cpuSlot1),
    .dram_req(dramReq1), .dram_addr(dramAddr1), .dram_rddata(dramRdData)
`ifdef VIDEO_ARB_SLOTCNT_EN
    , .int_start(intStart), .slot_cnt(slotCnt1)
`endif
  );

  video_arb_slot #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cend(cend), .pre_cend(preCend), .video_go(videoGo),
    .video_bw(videoBw), .video_addr(videoAddr), .video_next(videoNext3),
    .video_strobe(strobe3), .video_data(data3), .cpu_slot(cpuSlot3),
    .dram_req(dramReq3), .dram_addr(dramAddr3), .dram_rddata(dramRdData)
`ifdef VIDEO_ARB_SLOTCNT_EN
    , .int_start(intStart), .slot_cnt(slotCnt3)
`endif
  );

  function automatic logic [15:0] rdPattern(input int s);
    return 16'h5A00 + s[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clockStep(input logic p, input logic c);
    @(posedge clk);
    #1;
    preCend = p;
    cend    = c;
  endtask

  // One slot is four clocks: pre_cend, cend, two idle clocks
  task automatic applyStimulus(input int nSlots, input bit autoInc);
    int n0;
    for (int i = 0; i < nSlots; i++) begin
      slotIdx++;
      n0 = nextCnt;
      clockStep(1'b1, 1'b0);
      clockStep(1'b0, 1'b1);
      dramRdData = rdPattern(slotIdx);
      if (autoInc && (nextCnt != n0)) videoAddr = videoAddr + 21'd1;
      clockStep(1'b0, 1'b0);
      clockStep(1'b0, 1'b0);
    end
  endtask

  task automatic clearCounts();
    nextCnt = 0; reqCnt = 0; cpuCnt = 0; strobeCnt1 = 0; strobeCnt3 = 0;
    reqSlotQ.delete();
    reqAddrQ.delete();
  endtask

  // Observe on the falling edge and score returned words against their issuing slot
  always @(negedge clk) begin
    int s;
    if (videoNext1) nextCnt++;
    if (dramReq3 !== dramReq1) checkOutput("req3Match", {31'd0, dramReq3}, {31'd0, dramReq1});
    if (dramReq1) begin
      reqCnt++;
      sb1.push_back(slotIdx);
      sb3.push_back(slotIdx);
      reqSlotQ.push_back(slotIdx);
      reqAddrQ.push_back(dramAddr1);
    end
    if (cend && cpuSlot1) cpuCnt++;
    if (strobe1) begin
      strobeCnt1++;
      checkOutput("strobe1AfterCend", {31'd0, prevCend}, 32'd1);
      if (sb1.size() == 0) checkOutput("strobe1Unexpected", {31'd0, strobe1}, 32'd0);
      else begin
        s = sb1.pop_front();
        checkOutput("data1", {16'd0, data1}, {16'd0, rdPattern(s + 1)});
      end
    end
    if (strobe3) begin
      strobeCnt3++;
      checkOutput("strobe3AfterCend", {31'd0, prevCend}, 32'd1);
      if (sb3.size() == 0) checkOutput("strobe3Unexpected", {31'd0, strobe3}, 32'd0);
      else begin
        s = sb3.pop_front();
        checkOutput("data3", {16'd0, data3}, {16'd0, rdPattern(s + 3)});
      end
    end
    prevCend = cend;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int expC[4] = '{0, 4, 6, 8};
    rst = 1'b0; cend = 1'b0; preCend = 1'b0; videoGo = 1'b0;
    videoBw = 2'b00; videoAddr = 21'd0; dramRdData = 16'd0;
`ifdef VIDEO_ARB_SLOTCNT_EN
    intStart = 1'b0;
`endif
    clearCounts();
    #1 rst = 1'b1;
    #2;
    checkOutput("rstNext", {31'd0, videoNext1}, 32'd0);
    checkOutput("rstStrobe", {31'd0, strobe1}, 32'd0);
    checkOutput("rstData", {16'd0, data1}, 32'd0);
    checkOutput("rstCpuSlot", {31'd0, cpuSlot1}, 32'd0);
    checkOutput("rstReq", {31'd0, dramReq1}, 32'd0);
    checkOutput("rstAddr", {11'd0, dramAddr1}, 32'd0);
    checkOutput("rstPhase", {29'd0, dut.phase_q}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // bw 1/8 over 64 slots
    clearCounts();
    videoAddr = 21'h1ABCD; videoBw = 2'b00; videoGo = 1'b1;
    applyStimulus(64, 1'b0);
    checkOutput("aNext", nextCnt, 32'd8);
    checkOutput("aReq", reqCnt, 32'd8);
    checkOutput("aCpu", cpuCnt, 32'd56);
    checkOutput("aAddr", {11'd0, reqAddrQ[0]}, 32'h1ABCD);
    videoGo = 1'b0;
    applyStimulus(4, 1'b0);
    checkOutput("aStrobe1", strobeCnt1, 32'd8);
    checkOutput("aStrobe3", strobeCnt3, 32'd8);

    // every slot, incrementing address
    clearCounts();
    videoAddr = 21'd0; videoBw = 2'b11; videoGo = 1'b1;
    applyStimulus(10, 1'b1);
    checkOutput("bCpu", cpuCnt, 32'd0);
    checkOutput("bReq", reqCnt, 32'd10);
    foreach (reqAddrQ[k]) checkOutput("bAddrSeq", {11'd0, reqAddrQ[k]}, k);
    videoGo = 1'b0;
    applyStimulus(4, 1'b0);
    checkOutput("bStrobe1", strobeCnt1, 32'd10);
    checkOutput("bStrobe3", strobeCnt3, 32'd10);

    // bandwidth change 1/4 -> 1/2 between pre_cends
    clearCounts();
    videoAddr = 21'h00100; videoBw = 2'b01; videoGo = 1'b1;
    base = slotIdx + 1;
    applyStimulus(5, 1'b0);
    videoBw = 2'b10;
    applyStimulus(4, 1'b0);
    checkOutput("cNext", nextCnt, 32'd4);
    checkOutput("cReq", reqCnt, 32'd4);
    for (int k = 0; k < 4 && k < reqSlotQ.size(); k++)
      checkOutput("cSlotPos", reqSlotQ[k] - base, expC[k]);
    videoGo = 1'b0;
    applyStimulus(4, 1'b0);

    // video_go drops one clock after an issue; in-flight data still arrives
    clearCounts();
    videoBw = 2'b11; videoGo = 1'b1;
    slotIdx++;
    clockStep(1'b1, 1'b0);
    clockStep(1'b0, 1'b1);
    dramRdData = rdPattern(slotIdx);
    clockStep(1'b0, 1'b0);
    videoGo = 1'b0;
    clockStep(1'b0, 1'b0);
    checkOutput("dPhase", {29'd0, dut3.phase_q}, 32'd0);
    applyStimulus(4, 1'b0);
    checkOutput("dReq", reqCnt, 32'd1);
    checkOutput("dCpu", cpuCnt, 32'd4);
    checkOutput("dStrobe1", strobeCnt1, 32'd1);
    checkOutput("dStrobe3", strobeCnt3, 32'd1);
    checkOutput("dPhaseEnd", {29'd0, dut3.phase_q}, 32'd0);

    // reset with two reads in flight on the RD_LAT=3 instance
    clearCounts();
    videoBw = 2'b11; videoGo = 1'b1; videoAddr = 21'h0F0F0;
    applyStimulus(2, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; videoGo = 1'b0;
    sb1.delete();
    sb3.delete();
    #1;
    checkOutput("eNext3", {31'd0, videoNext3}, 32'd0);
    checkOutput("eStrobe3", {31'd0, strobe3}, 32'd0);
    checkOutput("eData3", {16'd0, data3}, 32'd0);
    checkOutput("eData1", {16'd0, data1}, 32'd0);
    checkOutput("eCpu3", {31'd0, cpuSlot3}, 32'd0);
    checkOutput("eReq3", {31'd0, dramReq3}, 32'd0);
    checkOutput("eAddr3", {11'd0, dramAddr3}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(5, 1'b0);
    checkOutput("eStrobeAfter1", strobeCnt1, 32'd1);
    checkOutput("eStrobeAfter3", strobeCnt3, 32'd0);

`ifdef VIDEO_ARB_SLOTCNT_EN
    videoBw = 2'b01; videoGo = 1'b1;
    @(posedge clk); #1 intStart = 1'b1;
    @(posedge clk); #1 intStart = 1'b0;
    applyStimulus(40, 1'b0);
    @(posedge clk); #1 intStart = 1'b1;
    @(posedge clk); #1 intStart = 1'b0;
    checkOutput("slotCnt1", {16'd0, slotCnt1}, 32'd10);
    checkOutput("slotCnt3", {16'd0, slotCnt3}, 32'd10);
    videoGo = 1'b0;
    applyStimulus(4, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
